async_fifo_wr_ctrl: RTL and testbench
=====================================

// Module: async_fifo_wr_ctrl
// PURPOSE
//  Write-side controller for an async FIFO built on the 16x8 dual-port RAM. It lives
//  entirely in the wr_clk domain and turns a push request into RAM write-port
//  controls. It publishes a Gray-coded write pointer for the read domain.
//  It synchronises the read-domain Gray pointer back in, to generate full,
//  almost_full and a fill count.
// PARAMETERS
//  ADDR_W       4   RAM address width; depth = 2**ADDR_W
//  DATA_W       8   data width
//  AF_THRESH    12  almost_full asserts when fill count >= AF_THRESH (1..2**ADDR_W)
//  SYNC_STAGES  2   flops in rd_ptr_gray synchroniser (>=2)
// PORTS
//  wr_clk        in   1         write clock
//  rst           in   1         reset, synchronous to wr_clk, active-high
//  push          in   1         push request; wr_data valid this cycle
//  wr_data       in   DATA_W    data to store
//  rd_ptr_gray   in   ADDR_W+1  read pointer, Gray, from rd_clk domain (async)
//  ram_wr_en     out  1         RAM write enable (= push & ~full), combinational
//  ram_wr_addr   out  ADDR_W    RAM write address (= wr_ptr_bin[ADDR_W-1:0])
//  ram_wr_data   out  DATA_W    wr_data passed through
//  wr_ptr_gray   out  ADDR_W+1  registered Gray write pointer to rd domain
//  full          out  1         FIFO full; pushes ignored while high
//  almost_full   out  1         fill count >= AF_THRESH
//  wr_count      out  ADDR_W+1  fill count as seen from write domain (pessimistic)
//  overflow      out  1         sticky push-while-full flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst high at wr_clk edge): wr_ptr_bin=0, wr_ptr_gray=0, sync flops=0,
//    full=0, almost_full=0, wr_count=0, overflow=0. Reset mid-operation discards
//    all contents. The read side must be reset in the same window.
//  - Pointers are ADDR_W+1 bits. The extra MSB distinguishes full from empty.
//    They wrap naturally 2**(ADDR_W+1)-1 -> 0. The address wraps 15 -> 0.
//  - Accept = push & ~full. The RAM captures data on the same wr_clk edge, so
//    write latency is 0 cycles from the accepting edge. On accept,
//    wr_ptr_bin <= wr_ptr_bin+1 and wr_ptr_gray <= bin2gray(wr_ptr_bin+1).
//  - Push while full: no RAM write, no pointer change.
//  - rd_ptr_gray passes through SYNC_STAGES flops to give rd_sync, then
//    rd_bin = gray2bin(rd_sync). No logic sits between the synchroniser stages.
//  - Flags are registered and computed from next-state values:
//    full <= (gray_next == {~rd_sync[ADDR_W:ADDR_W-1], rd_sync[ADDR_W-2:0]});
//    wr_count <= bin_next - rd_bin (mod 2**(ADDR_W+1));
//    almost_full <= (bin_next - rd_bin) >= AF_THRESH.
//  - full therefore rises on the same edge as the write that fills the last slot.
//    It falls SYNC_STAGES+1 wr_clk edges after the read pointer advances.
//    wr_count/almost_full lag reads by the same amount, so they never under-report.
//  - A push and a read-pointer update in the same cycle are independent. A push
//    is never accepted while full is high, even if a read is in flight.
// CONFIGURATION
//  - Macro FIFO_WR_OVERFLOW_EN defined: overflow is set on any push while full,
//    and cleared only by rst.
//  - Macro not defined: overflow is tied to 0 and no flop is inferred.
//  - The port list is identical either way.
// STRUCTURE
//  - Shared package/include fifo_pkg: default ADDR_W/DATA_W constants, and
//    functions bin2gray(x) = x ^ (x>>1) and gray2bin (prefix XOR). The read-side
//    controller reuses these.
//  - One sub-module, ptr_sync: a SYNC_STAGES-deep, WIDTH-bit flop chain with
//    synchronous reset. It is shared with the read-side controller.
// TESTING
//  1 Reset: rst=1 for 2 edges, with push and rd_ptr_gray toggling -> all outputs 0.
//    No ram_wr_en while rst is high.
//  2 Fill: rd_ptr_gray=0, push 16 words 0x00..0x0F.
//    -> ram_wr_addr 0..15 with matching data; almost_full rises after the 12th
//    push; full rises on the 16th edge; wr_ptr_gray=5'b11000; wr_count=16.
//  3 Push while full: push=1 with data 0xAA for 3 cycles -> ram_wr_en=0,
//    pointer unchanged. overflow=1 with FIFO_WR_OVERFLOW_EN, 0 without.
//  4 Drain release: from full, set rd_ptr_gray=bin2gray(1).
//    -> full drops exactly SYNC_STAGES+1 edges later; wr_count=15.
//  5 Wrap: 40 interleaved pushes/reads, keeping the read pointer 3 behind.
//    -> address wraps 15->0; full never asserts; the pointer MSB toggles twice;
//    each wr_ptr_gray step changes exactly 1 bit.
//  6 Mid-op reset: after 7 pushes assert rst for 1 edge -> pointers, wr_count and
//    flags are 0. The next push writes address 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the async FIFO write- and read-side controllers.
//   Provides the default RAM geometry and the Gray/binary conversion helpers.
//   Helpers work on a 32-bit container. Callers zero-extend narrower pointers
//   on the way in and truncate on the way out. Leading zeros do not change
//   either conversion.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_ADDR_W = 4;
  localparam int FIFO_DATA_W = 8;

  // Binary to Gray: each bit is the XOR of itself and the next higher bit.
  function automatic logic [31:0] bin2gray(input logic [31:0] x);
    return x ^ (x >> 1);
  endfunction

  // Gray to binary: prefix XOR from the MSB downwards.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// -----------------------------------------------------------------------------
// ptr_sync
//   A plain STAGES-deep flop chain for bringing a Gray pointer across a clock
//   domain. There is no logic between the stages. The chain resets
//   synchronously to zero.
// Ports
//   clk  in   1      destination-domain clock
//   rst  in   1      synchronous active-high reset
//   d    in   WIDTH  asynchronous input (Gray coded)
//   q    out  WIDTH  synchronised output (last stage)
// -----------------------------------------------------------------------------
module ptr_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// async_fifo_wr_ctrl
//   Write-side controller for an async FIFO on a 2**ADDR_W x DATA_W dual-port
//   RAM. It runs entirely in the wr_clk domain and turns push into RAM write
//   controls. It publishes a registered Gray write pointer for the read
//   domain. It synchronises the read Gray pointer back in and derives
//   registered full, almost_full and wr_count flags. These flags are
//   pessimistic and never under-report the fill level.
//
//   Handshake: a word is accepted on a wr_clk edge when push is high and full
//   is low in the cycle before that edge. The RAM captures wr_data on that same
//   edge. A push while full is dropped and does not change the pointer.
//
//   Build option: define FIFO_WR_OVERFLOW_EN to get a sticky overflow flag.
//   The flag sets on any push while full and clears only on rst. Without the
//   macro, overflow is tied low. The port list is the same either way.
//
// Ports
//   wr_clk       in   1         write clock
//   rst          in   1         synchronous active-high reset
//   push         in   1         push request, wr_data valid this cycle
//   wr_data      in   DATA_W    data to store
//   rd_ptr_gray  in   ADDR_W+1  read pointer (Gray) from the read domain
//   ram_wr_en    out  1         RAM write enable (combinational)
//   ram_wr_addr  out  ADDR_W    RAM write address
//   ram_wr_data  out  DATA_W    wr_data passed through
//   wr_ptr_gray  out  ADDR_W+1  registered Gray write pointer
//   full         out  1         FIFO full
//   almost_full  out  1         fill count >= AF_THRESH
//   wr_count     out  ADDR_W+1  fill count seen from the write domain
//   overflow     out  1         sticky push-while-full flag (optional)
// -----------------------------------------------------------------------------
module async_fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W      = FIFO_ADDR_W,
  parameter int DATA_W      = FIFO_DATA_W,
  parameter int AF_THRESH   = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic              wr_clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W:0]   rd_ptr_gray,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_count,
  output logic              overflow
);

  localparam int PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0] wr_ptr_bin;
  logic [PTR_W-1:0] bin_next;
  logic [PTR_W-1:0] gray_next;
  logic [PTR_W-1:0] rd_sync;
  logic [PTR_W-1:0] rd_bin;
  logic [PTR_W-1:0] fill_next;
  logic             full_next;
  logic             accept;

  // Read pointer crossing: a bare flop chain. The Gray coding means that at
  // most one bit is ever in flight.
  ptr_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .clk (wr_clk),
    .rst (rst),
    .d   (rd_ptr_gray),
    .q   (rd_sync)
  );

  // The write is also held off during reset. This stops a stray RAM write
  // while the pointer is being cleared.
  assign accept      = push & ~full & ~rst;
  assign ram_wr_en   = accept;
  assign ram_wr_addr = wr_ptr_bin[ADDR_W-1:0];
  assign ram_wr_data = wr_data;

  assign bin_next  = wr_ptr_bin + PTR_W'(accept);
  assign gray_next = PTR_W'(bin2gray(32'(bin_next)));
  assign rd_bin    = PTR_W'(gray2bin(32'(rd_sync)));
  assign fill_next = bin_next - rd_bin;

  // Full when the next write pointer is exactly one lap ahead of the read
  // pointer. In Gray this means the top two bits are inverted and the rest
  // are equal.
  assign full_next = (gray_next == {~rd_sync[PTR_W-1:PTR_W-2], rd_sync[PTR_W-3:0]});

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      wr_ptr_bin  <= '0;
      wr_ptr_gray <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_count    <= '0;
    end else begin
      wr_ptr_bin  <= bin_next;
      wr_ptr_gray <= gray_next;
      full        <= full_next;
      almost_full <= (int'(fill_next) >= AF_THRESH);
      wr_count    <= fill_next;
    end
  end

`ifdef FIFO_WR_OVERFLOW_EN
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push && full) begin
      overflow <= 1'b1;
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_async_fifo_wr_ctrl
//   Checks async_fifo_wr_ctrl against a count-based reference model. The model
//   tracks the total words written, and the read pointer counts as the write
//   domain sees them after the synchroniser delay.
// -----------------------------------------------------------------------------
module tb_async_fifo_wr_ctrl;

  localparam int SYNC = 2;

  logic       wr_clk = 1'b0;
  logic       rst = 1'b1;
  logic       push = 1'b0;
  logic [7:0] wr_data = '0;
  logic [4:0] rd_ptr_gray = '0;
  logic       ram_wr_en;
  logic [3:0] ram_wr_addr;
  logic [7:0] ram_wr_data;
  logic [4:0] wr_ptr_gray;
  logic       full;
  logic       almost_full;
  logic [4:0] wr_count;
  logic       overflow;

  async_fifo_wr_ctrl dut (
    .wr_clk      (wr_clk),
    .rst         (rst),
    .push        (push),
    .wr_data     (wr_data),
    .rd_ptr_gray (rd_ptr_gray),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .wr_ptr_gray (wr_ptr_gray),
    .full        (full),
    .almost_full (almost_full),
    .wr_count    (wr_count),
    .overflow    (overflow)
  );

  // clock / reset block
  always #5 wr_clk = ~wr_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];   // data expected at the RAM write port, in order

  // reference model
  int   m_wr   = 0;       // total words accepted since reset
  int   m_rdq[$];         // read counts in flight through the synchroniser
  logic m_full = 1'b0;
  logic m_af   = 1'b0;
  int   m_cnt  = 0;
  logic m_ovf  = 1'b0;

  function automatic logic [4:0] gray5(input int c);
    int b;
    b = c & 31;
    return 5'(b ^ (b >> 1));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_wr = 0; m_full = 0; m_af = 0; m_cnt = 0; m_ovf = 0;
    m_rdq.delete();
    for (int i = 0; i < SYNC; i++) m_rdq.push_back(0);
  endtask

  // driver: one wr_clk cycle. This task is entered at the negative edge.
  // It drives the inputs, checks the write port before the edge, updates the
  // model at the edge and checks the registered outputs at the next negedge.
  task automatic step(input logic p, input logic [7:0] d, input int rd_cnt, input logic r,
                      output logic en_o, output logic [3:0] addr_o);
    logic exp_en;
    int   seen;
    int   occ;
    push = p; wr_data = d; rd_ptr_gray = gray5(rd_cnt); rst = r;
    #1;
    exp_en = !r && p && !m_full;
    en_o = ram_wr_en;
    addr_o = ram_wr_addr;
    check("ram_wr_en", ram_wr_en, exp_en);
    if (exp_en) begin
      exp_q.push_back(d);
      check("ram_wr_addr", ram_wr_addr, m_wr & 15);
      check("ram_wr_data", ram_wr_data, exp_q.pop_front());
    end
    @(posedge wr_clk);
    if (r) begin
      model_reset();
    end else begin
      if (p && m_full) m_ovf = 1'b1;
      if (exp_en) m_wr++;
      seen = m_rdq.pop_front();
      m_rdq.push_back(rd_cnt);
      occ = (m_wr - seen) & 31;
      m_full = (occ == 16);
      m_af = (occ >= 12);
      m_cnt = occ;
    end
    @(negedge wr_clk);
    check("full", full, m_full);
    check("almost_full", almost_full, m_af);
    check("wr_count", wr_count, m_cnt);
    check("wr_ptr_gray", wr_ptr_gray, gray5(m_wr));
`ifdef FIFO_WR_OVERFLOW_EN
    check("overflow", overflow, m_ovf);
`else
    check("overflow", overflow, 1'b0);
`endif
  endtask

  typedef struct {
    logic       push;
    logic [7:0] data;
    int         rd;
    logic       exp_en;
    logic [3:0] exp_addr;
    logic       exp_full;
    logic       exp_af;
    logic [4:0] exp_cnt;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic       en;
    logic [3:0] addr;
    logic [4:0] prev_gray;
    logic [3:0] prev_addr;
    int         msb_toggles;
    logic       wrapped;
    int         rd_tot;
    vec_t       v;

    // fill, push-while-full and drain-release table
    for (int i = 0; i < 16; i++) begin
      v = '{1'b1, 8'(i), 0, 1'b1, 4'(i), (i == 15), (i + 1 >= 12), 5'(i + 1)};
      tbl.push_back(v);
    end
    for (int i = 0; i < 3; i++) begin
      v = '{1'b1, 8'hAA, 0, 1'b0, 4'd0, 1'b1, 1'b1, 5'd16};
      tbl.push_back(v);
    end
    // the read pointer advances to 1; full drops on the SYNC+1-th edge
    tbl.push_back('{1'b0, 8'h00, 1, 1'b0, 4'd0, 1'b1, 1'b1, 5'd16});
    tbl.push_back('{1'b0, 8'h00, 1, 1'b0, 4'd0, 1'b1, 1'b1, 5'd16});
    tbl.push_back('{1'b0, 8'h00, 1, 1'b0, 4'd0, 1'b0, 1'b1, 5'd15});

    model_reset();
    @(negedge wr_clk);

    // 1: reset with the inputs toggling
    step(1'b1, 8'h11, 5, 1'b1, en, addr);
    step(1'b0, 8'h22, 9, 1'b1, en, addr);
    check("rst_wr_en", en, 1'b0);
    check("rst_outputs", {full, almost_full, wr_count, wr_ptr_gray, overflow}, '0);

    // 2-4: table-driven fill / push-while-full / drain
    foreach (tbl[i]) begin
      step(tbl[i].push, tbl[i].data, tbl[i].rd, 1'b0, en, addr);
      check("tbl_en", en, tbl[i].exp_en);
      if (tbl[i].exp_en) check("tbl_addr", addr, tbl[i].exp_addr);
      check("tbl_full", full, tbl[i].exp_full);
      check("tbl_af", almost_full, tbl[i].exp_af);
      check("tbl_cnt", wr_count, tbl[i].exp_cnt);
      if (i == 15) check("full_gray", wr_ptr_gray, 5'b11000);
    end
`ifdef FIFO_WR_OVERFLOW_EN
    check("ovf_sticky", overflow, 1'b1);
`else
    check("ovf_off", overflow, 1'b0);
`endif

    // 5: wrap with the read pointer kept 3 behind
    step(1'b0, 8'h00, 0, 1'b1, en, addr);
    prev_gray = wr_ptr_gray;
    prev_addr = 4'd0;
    msb_toggles = 0;
    wrapped = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'($urandom_range(0, 255)), (m_wr > 3) ? m_wr - 3 : 0, 1'b0, en, addr);
      check("wrap_no_full", full, 1'b0);
      check("gray_1bit", $countones(prev_gray ^ wr_ptr_gray), 1);
      if (prev_gray[4] != wr_ptr_gray[4]) msb_toggles++;
      if (prev_addr == 4'd15 && addr == 4'd0) wrapped = 1'b1;
      prev_gray = wr_ptr_gray;
      prev_addr = addr;
    end
    check("msb_toggles", msb_toggles, 2);
    check("addr_wrapped", wrapped, 1'b1);

    // randomized traffic against the model
    step(1'b0, 8'h00, 0, 1'b1, en, addr);
    rd_tot = 0;
    for (int i = 0; i < 400; i++) begin
      if (rd_tot < m_wr && $urandom_range(0, 2) == 0) rd_tot++;
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), rd_tot, 1'b0, en, addr);
    end

    // 6: mid-operation reset
    step(1'b0, 8'h00, 0, 1'b1, en, addr);
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h30 + i), 0, 1'b0, en, addr);
    step(1'b1, 8'h77, 0, 1'b1, en, addr);
    check("midrst_zero", {full, almost_full, wr_count, wr_ptr_gray}, '0);
    step(1'b1, 8'h5A, 0, 1'b0, en, addr);
    check("midrst_en", en, 1'b1);
    check("midrst_addr0", addr, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
